// File: rtl/bit_serial_pkg.sv
// Shared types and helpers for the bit-serial sequencer.
// Zero-plane skipping is compiled in with BIT_SERIAL_ZERO_SKIP_EN.
package bit_serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    SKIP  = 2'd2
  } ctrl_state_t;

  localparam int DEFAULT_DATA_WIDTH = 8;

  function automatic int idx_width(input int dw);
    return (dw > 1) ? $clog2(dw) : 1;
  endfunction

  // Lowest bit plane emitted for a left-aligned operand of the given precision.
  function automatic int calc_stop(input int prec, input int dw);
    return (prec == 0 || prec > dw) ? 0 : dw - prec;
  endfunction

endpackage

// File: rtl/bit_serial_seq_ctrl_lowest_set_finder.sv
// Priority encoder returning the lowest set bit of a plane mask.
// Provides the plane that carries the out_last marker.
module lowest_set_finder
  import bit_serial_pkg::*;
#(
  parameter int W  = DEFAULT_DATA_WIDTH,
  parameter int IW = idx_width(W)
) (
  input  logic [W-1:0]  vec,
  output logic [IW-1:0] low,
  output logic          found
);

  always_comb begin
    low   = '0;
    found = 1'b0;
    for (int j = W - 1; j >= 0; j--) begin
      if (vec[j]) begin
        low   = IW'(j);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bit_serial_seq_ctrl.sv
// Load/step sequencer for one bit-serial register file column group, MSB first.
// Optional zero-plane skipping: define BIT_SERIAL_ZERO_SKIP_EN.
//
// state | meaning
// IDLE  | no operand held, ready for a load
// SHIFT | presenting plane idx to the PE array
// SKIP  | stepping past an all-zero plane without presenting it
module bit_serial_seq_ctrl
  import bit_serial_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int IDX_W      = idx_width(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IDX_W:0]        in_prec,
  input  logic [DATA_WIDTH-1:0] in_plane_nz,
  output logic                  rf_w_en,
  output logic                  rf_r_en,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [IDX_W-1:0]      out_bit_idx,
  output logic                  out_first,
  output logic                  out_last,
  output logic                  busy
);

  localparam logic [IDX_W-1:0]      IDX_MSB  = IDX_W'(DATA_WIDTH - 1);
  localparam logic [DATA_WIDTH-1:0] MSB_ONLY = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  ctrl_state_t           state;
  logic [IDX_W-1:0]      idx;
  logic [DATA_WIDTH-1:0] mask;
  logic                  first;

  logic [IDX_W-1:0]      stop_ld;
  logic [IDX_W-1:0]      idx_dec;
  logic [IDX_W-1:0]      low;
  logic                  found;
  logic [DATA_WIDTH-1:0] win;
  logic [DATA_WIDTH-1:0] load_mask;
  logic                  in_shift;
  logic                  accept;
  logic                  is_last;
  logic                  load;

  always_comb begin
    stop_ld = IDX_W'(calc_stop(int'(in_prec), DATA_WIDTH));
    win     = '0;
    for (int j = 0; j < DATA_WIDTH; j++) begin
      win[j] = (j >= int'(stop_ld));
    end
  end

`ifdef BIT_SERIAL_ZERO_SKIP_EN
  logic [DATA_WIDTH-1:0] nz_win;
  assign nz_win = in_plane_nz & win;
  // An operand with no set plane still produces one beat at the MSB.
  assign load_mask = (|nz_win) ? nz_win : MSB_ONLY;
`else
  logic unused_plane_nz;
  assign unused_plane_nz = ^in_plane_nz;
  assign load_mask = win;
`endif

  // The mask register holds exactly the planes to present; the last beat is its lowest bit.
  lowest_set_finder #(.W(DATA_WIDTH), .IW(IDX_W)) u_low (
    .vec   (mask),
    .low   (low),
    .found (found)
  );

  assign in_shift = (state == SHIFT);
  assign is_last  = in_shift & found & (idx == low);
  assign accept   = in_shift & out_ready;
  assign idx_dec  = idx - IDX_W'(1);

  assign in_ready    = (state == IDLE) | (accept & is_last);
  assign load        = in_valid & in_ready;
  assign rf_w_en     = load;
  assign rf_r_en     = (accept & ~is_last) | (state == SKIP);
  assign out_valid   = in_shift;
  assign out_bit_idx = in_shift ? idx : '0;
  assign out_first   = in_shift & first;
  assign out_last    = is_last;
  assign busy        = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
      mask  <= '0;
      first <= 1'b0;
    end else if (load) begin
      // A load on the last-beat cycle takes priority, giving bubble-free back-to-back operands.
      idx   <= IDX_MSB;
      first <= 1'b1;
      mask  <= load_mask;
`ifdef BIT_SERIAL_ZERO_SKIP_EN
      state <= load_mask[DATA_WIDTH-1] ? SHIFT : SKIP;
`else
      state <= SHIFT;
`endif
    end else begin
      case (state)
        SHIFT: begin
          if (out_ready) begin
            if (is_last) begin
              state <= IDLE;
            end else begin
              idx   <= idx_dec;
              first <= 1'b0;
`ifdef BIT_SERIAL_ZERO_SKIP_EN
              state <= mask[idx_dec] ? SHIFT : SKIP;
`endif
            end
          end
        end
        SKIP: begin
          idx <= idx_dec;
          if (mask[idx_dec]) state <= SHIFT;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serial_seq_ctrl.sv
// Self-checking bench for bit_serial_seq_ctrl against a beat-schedule reference model.
// Zero-skip scenarios are included when BIT_SERIAL_ZERO_SKIP_EN is defined.
module tb_bit_serial_seq_ctrl;

  localparam int DW = 8;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [IW:0]   in_prec;
  logic [DW-1:0] in_plane_nz;
  logic          rf_w_en;
  logic          rf_r_en;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_bit_idx;
  logic          out_first;
  logic          out_last;
  logic          busy;

  always #5 clk = ~clk;

  bit_serial_seq_ctrl #(.DATA_WIDTH(DW), .IDX_W(IW)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_prec     (in_prec),
    .in_plane_nz (in_plane_nz),
    .rf_w_en     (rf_w_en),
    .rf_r_en     (rf_r_en),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_bit_idx (out_bit_idx),
    .out_first   (out_first),
    .out_last    (out_last),
    .busy        (busy)
  );

  // One scheduled cycle of an operand: a presented beat or a skipped plane.
  typedef struct packed {
    logic          beat;
    logic [IW-1:0] idx;
    logic          first;
    logic          last;
  } ev_t;

  typedef struct packed {
    logic [IW:0]   prec;
    logic [DW-1:0] nz;
  } op_t;

  ev_t  sched[$];
  op_t  pend[$];
  bit   ready_q[$];
  logic [IW-1:0] beat_log[$];
  int   beat_cyc[$];
  int   r_en_cnt;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   ready_mode;
  bit   valid_rand;
  bit   holding;

  function automatic logic [DW-1:0] plane_set(input op_t o);
    int p;
    logic [DW-1:0] m;
    p = (o.prec == 0) ? DW : int'(o.prec);
    m = '0;
    for (int j = DW - p; j < DW; j++) m[j] = 1'b1;
`ifdef BIT_SERIAL_ZERO_SKIP_EN
    m = m & o.nz;
    if (m == 0) m[DW-1] = 1'b1;
`endif
    return m;
  endfunction

  function automatic void build_sched(input op_t o);
    logic [DW-1:0] m;
    int low;
    bit seen;
    ev_t e;
    m = plane_set(o);
    low = 0;
    for (int j = DW - 1; j >= 0; j--) if (m[j]) low = j;
    seen = 1'b0;
    for (int j = DW - 1; j >= low; j--) begin
      e.beat  = m[j];
      e.idx   = IW'(j);
      e.first = m[j] && !seen;
      e.last  = m[j] && (j == low);
      if (m[j]) seen = 1'b1;
      sched.push_back(e);
    end
  endfunction

  task automatic clear_logs();
    beat_log.delete();
    beat_cyc.delete();
    r_en_cnt = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    sched.delete();
    holding = 1'b0;
  endtask

  task automatic run_stream(input string name, input int max_cyc, input int abort_idx,
                            output bit aborted);
    logic [9:0] exp_v, act_v;
    bit ev_valid, acc, ex_ready, ex_w, ex_r, done;
    aborted = 1'b0;
    done = 1'b0;
    for (int c = 0; c < max_cyc && !done; c++) begin
      @(negedge clk);
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 9) < 7);
        default: out_ready = (ready_q.size() > 0) ? ready_q.pop_front() : 1'b1;
      endcase
      if (pend.size() > 0 && (holding || !valid_rand || $urandom_range(0, 2) != 0)) begin
        in_valid    = 1'b1;
        in_prec     = pend[0].prec;
        in_plane_nz = pend[0].nz;
        holding     = 1'b1;
      end else begin
        in_valid    = 1'b0;
        in_prec     = (IW+1)'($urandom_range(0, 15));
        in_plane_nz = DW'($urandom);
      end
      #1;
      if (abort_idx >= 0 && sched.size() > 0 && sched[0].beat && int'(sched[0].idx) == abort_idx) begin
        aborted = 1'b1;
        return;
      end
      ev_valid = sched.size() > 0 && sched[0].beat;
      acc      = ev_valid && out_ready;
      ex_ready = (sched.size() == 0) || (acc && sched[0].last);
      ex_w     = in_valid && ex_ready;
      ex_r     = sched.size() > 0 && (!sched[0].beat || (acc && !sched[0].last));
      exp_v = {sched.size() > 0, ex_ready, ex_w, ex_r, ev_valid,
               ev_valid && sched[0].first, ev_valid && sched[0].last,
               ev_valid ? sched[0].idx : IW'(0)};
      act_v = {busy, in_ready, rf_w_en, rf_r_en, out_valid, out_first, out_last, out_bit_idx};
      n_tests++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL %s cycle %0d: {busy,in_ready,w_en,r_en,valid,first,last,idx} got %b expected %b",
                 name, c, act_v, exp_v);
      end
      if (out_valid && out_ready) begin
        beat_log.push_back(out_bit_idx);
        beat_cyc.push_back(c);
      end
      if (rf_r_en) r_en_cnt++;
      if (sched.size() > 0 && (!sched[0].beat || acc)) void'(sched.pop_front());
      if (ex_w) begin
        build_sched(pend.pop_front());
        holding = 1'b0;
      end
      done = (pend.size() == 0 && sched.size() == 0);
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s timeout: stream still active after %0d cycles, required completion", name, max_cyc);
      pend.delete();
      apply_reset();
    end
  endtask

  task automatic push_op(input int prec, input logic [DW-1:0] nz);
    op_t o;
    o.prec = (IW+1)'(prec);
    o.nz   = nz;
    pend.push_back(o);
  endtask

  task automatic test_reset();
    logic [9:0] act_v;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_prec = '0; in_plane_nz = '0;
    repeat (2) @(negedge clk);
    #1;
    act_v = {busy, in_ready, rf_w_en, rf_r_en, out_valid, out_first, out_last, out_bit_idx};
    n_tests++;
    if (act_v !== 10'b01_0000_0000) begin
      n_fail++;
      $display("FAIL reset_hold: outputs got %b expected %b", act_v, 10'b01_0000_0000);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    act_v = {busy, in_ready, rf_w_en, rf_r_en, out_valid, out_first, out_last, out_bit_idx};
    n_tests++;
    if (act_v !== 10'b01_0000_0000) begin
      n_fail++;
      $display("FAIL reset_release: outputs got %b expected %b", act_v, 10'b01_0000_0000);
    end
  endtask

  task automatic test_full_prec();
    bit ab;
    bit bad;
    clear_logs(); ready_mode = 0; valid_rand = 1'b0;
    push_op(0, 8'hFF);
    run_stream("full_prec", 40, -1, ab);
    bad = (beat_log.size() != 8);
    for (int i = 0; i < beat_log.size() && i < 8; i++) if (beat_log[i] != IW'(7 - i)) bad = 1'b1;
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL full_prec_order: got %0d beats starting idx %0d, required 8 beats 7..0",
               beat_log.size(), beat_log.size() > 0 ? beat_log[0] : 0);
    end
    n_tests++;
    if (r_en_cnt != 7) begin
      n_fail++;
      $display("FAIL full_prec_r_en: got %0d shift pulses, required 7", r_en_cnt);
    end
  endtask

  task automatic test_prec3_b2b();
    bit ab;
    clear_logs(); ready_mode = 0; valid_rand = 1'b0;
    push_op(3, 8'hFF);
    push_op(0, 8'hFF);
    run_stream("prec3_b2b", 60, -1, ab);
    n_tests++;
    if (beat_log.size() != 11) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d beats, required 11", beat_log.size());
    end else begin
      n_tests++;
      if (beat_log[0] != 3'd7 || beat_log[1] != 3'd6 || beat_log[2] != 3'd5 || beat_log[3] != 3'd7) begin
        n_fail++;
        $display("FAIL b2b_idx: got %0d %0d %0d %0d, required 7 6 5 7",
                 beat_log[0], beat_log[1], beat_log[2], beat_log[3]);
      end
      n_tests++;
      if (beat_cyc[3] != beat_cyc[2] + 1) begin
        n_fail++;
        $display("FAIL b2b_bubble: next operand beat at cycle %0d, required %0d", beat_cyc[3], beat_cyc[2] + 1);
      end
    end
    n_tests++;
    if (r_en_cnt != 9) begin
      n_fail++;
      $display("FAIL b2b_r_en: got %0d shift pulses, required 9", r_en_cnt);
    end
  endtask

  task automatic test_stall();
    bit ab;
    clear_logs(); ready_mode = 2; valid_rand = 1'b0;
    ready_q = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    push_op(0, 8'hFF);
    run_stream("stall", 40, -1, ab);
    n_tests++;
    if (beat_log.size() != 8 || r_en_cnt != 7) begin
      n_fail++;
      $display("FAIL stall_totals: got %0d beats / %0d shifts, required 8 / 7", beat_log.size(), r_en_cnt);
    end
    ready_mode = 0;
  endtask

  task automatic test_reset_mid();
    bit ab;
    logic [9:0] act_v;
    clear_logs(); ready_mode = 0; valid_rand = 1'b0;
    push_op(0, 8'hFF);
    run_stream("reset_mid_pre", 40, 4, ab);
    n_tests++;
    if (!ab) begin
      n_fail++;
      $display("FAIL reset_mid_reach: idx 4 beat got not-presented, required presented");
    end
    reset = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    sched.delete(); pend.delete(); holding = 1'b0;
    #1;
    act_v = {busy, in_ready, rf_w_en, rf_r_en, out_valid, out_first, out_last, out_bit_idx};
    n_tests++;
    if (act_v !== 10'b01_0000_0000) begin
      n_fail++;
      $display("FAIL reset_mid_idle: outputs got %b expected %b", act_v, 10'b01_0000_0000);
    end
    clear_logs();
    push_op(0, 8'hFF);
    run_stream("reset_mid_post", 40, -1, ab);
    n_tests++;
    if (beat_log.size() != 8 || beat_log[0] != 3'd7) begin
      n_fail++;
      $display("FAIL reset_mid_restart: got %0d beats first idx %0d, required 8 beats first idx 7",
               beat_log.size(), beat_log.size() > 0 ? beat_log[0] : 0);
    end
  endtask

`ifdef BIT_SERIAL_ZERO_SKIP_EN
  task automatic test_zero_skip();
    bit ab;
    clear_logs(); ready_mode = 0; valid_rand = 1'b0;
    push_op(0, 8'b0010_0100);
    run_stream("zero_skip", 40, -1, ab);
    n_tests++;
    if (beat_log.size() != 2 || beat_log[0] != 3'd5 || beat_log[1] != 3'd2) begin
      n_fail++;
      $display("FAIL zero_skip_idx: got %0d beats, required beats at 5 and 2", beat_log.size());
    end else begin
      n_tests++;
      if (beat_cyc[0] != 3) begin
        n_fail++;
        $display("FAIL zero_skip_lead: first beat at cycle %0d, required 3", beat_cyc[0]);
      end
    end
    n_tests++;
    if (r_en_cnt != 5) begin
      n_fail++;
      $display("FAIL zero_skip_r_en: got %0d shift pulses, required 5", r_en_cnt);
    end
    clear_logs();
    push_op(0, 8'h00);
    run_stream("zero_all", 20, -1, ab);
    n_tests++;
    if (beat_log.size() != 1 || beat_log[0] != 3'd7 || r_en_cnt != 0) begin
      n_fail++;
      $display("FAIL zero_all: got %0d beats / %0d shifts, required 1 beat at 7 / 0", beat_log.size(), r_en_cnt);
    end
  endtask
`endif

  task automatic test_random();
    bit ab;
    int exp_beats;
    op_t o;
    clear_logs(); ready_mode = 1; valid_rand = 1'b1;
    exp_beats = 0;
    for (int i = 0; i < 60; i++) begin
      o.prec = (IW+1)'($urandom_range(0, DW));
      o.nz   = DW'($urandom);
      exp_beats += $countones(plane_set(o));
      pend.push_back(o);
    end
    run_stream("random", 3000, -1, ab);
    n_tests++;
    if (beat_log.size() != exp_beats) begin
      n_fail++;
      $display("FAIL random_beats: got %0d beats, required %0d", beat_log.size(), exp_beats);
    end
    ready_mode = 0; valid_rand = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_prec = '0; in_plane_nz = '0;
    ready_mode = 0; valid_rand = 1'b0; holding = 1'b0; r_en_cnt = 0;
    test_reset();
    test_full_prec();
    test_prec3_b2b();
    test_stall();
    test_reset_mid();
`ifdef BIT_SERIAL_ZERO_SKIP_EN
    test_zero_skip();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
